// File: rtl/morracinese_param_if.sv
// -----------------------------------------------------------------------------
// morracinese_param_if
// Bundles the move inputs and result outputs of the morra cinese referee.
//   primo, secondo : player moves (also the MAX configuration while reset is high)
//   manche         : result of the last sampled manche
//   partita        : game result
//   score1, score2 : manche wins per player
//   rounds         : valid manches played
//   game_over      : high while the game is finished
// Modports: master = move source (test environment), slave = referee.
// -----------------------------------------------------------------------------
interface morracinese_param_if #(
   parameter int CNT_W = 5
);
   logic [1:0]       primo;
   logic [1:0]       secondo;
   logic [1:0]       manche;
   logic [1:0]       partita;
   logic [CNT_W-1:0] score1;
   logic [CNT_W-1:0] score2;
   logic [CNT_W-1:0] rounds;
   logic             game_over;

   modport master (
      output primo, secondo,
      input  manche, partita, score1, score2, rounds, game_over
   );

   modport slave (
      input  primo, secondo,
      output manche, partita, score1, score2, rounds, game_over
   );
endinterface

// File: rtl/morracinese_param.sv
// -----------------------------------------------------------------------------
// morracinese_param
// Rock-paper-scissors referee. One manche is sampled per clock while the game
// runs; results are registered, so they appear on the outputs one cycle later.
// The game ends when the manche count reaches MAX, or once MIN_ROUNDS manches
// have been played and one player leads by WIN_LEAD.
//   clk    : single clock, rising edge
//   reset  : synchronous active-high; loads MAX = MIN_ROUNDS + {primo,secondo}
//   bus    : slave side of morracinese_param_if (moves in, results out)
// -----------------------------------------------------------------------------
module morracinese_param #(
   parameter int MIN_ROUNDS = 4,
   parameter int WIN_LEAD   = 2,
   parameter int NO_REPEAT  = 1,
   parameter int CNT_W      = 5
) (
   input logic                 clk,
   input logic                 reset,
   morracinese_param_if.slave  bus
);

   localparam logic [1:0] MV_NONE    = 2'b00;
   localparam logic [1:0] MV_SASSO   = 2'b01;
   localparam logic [1:0] MV_CARTA   = 2'b10;
   localparam logic [1:0] MV_FORBICE = 2'b11;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_P1   = 2'b01,
      RES_P2   = 2'b10,
      RES_DRAW = 2'b11
   } result_t;

   typedef enum logic {
      ST_PLAY,
      ST_OVER
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] max_rounds;
   result_t          last_winner;   // RES_NONE when no decisive manche is on record
   logic [1:0]       last_move;

   logic             p1_beats;
   logic             p2_beats;
   logic             repeat_block;
   logic             valid;
   result_t          outcome;
   logic [CNT_W-1:0] rounds_nx;
   logic [CNT_W-1:0] score1_nx;
   logic [CNT_W-1:0] score2_nx;
   logic [CNT_W:0]   lead;
   logic             finish;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      p1_beats     = 1'b0;
      p2_beats     = 1'b0;
      repeat_block = 1'b0;
      valid        = 1'b0;
      outcome      = RES_NONE;
      rounds_nx    = bus.rounds;
      score1_nx    = bus.score1;
      score2_nx    = bus.score2;
      lead         = '0;
      finish       = 1'b0;

      p1_beats = (bus.primo == MV_SASSO   && bus.secondo == MV_FORBICE) ||
                 (bus.primo == MV_FORBICE && bus.secondo == MV_CARTA)   ||
                 (bus.primo == MV_CARTA   && bus.secondo == MV_SASSO);
      p2_beats = (bus.secondo == MV_SASSO   && bus.primo == MV_FORBICE) ||
                 (bus.secondo == MV_FORBICE && bus.primo == MV_CARTA)   ||
                 (bus.secondo == MV_CARTA   && bus.primo == MV_SASSO);

      // The last decisive winner may not reuse the move that won, whatever the opponent plays.
      if (NO_REPEAT != 0) begin
         repeat_block = (last_winner == RES_P1 && bus.primo   == last_move) ||
                        (last_winner == RES_P2 && bus.secondo == last_move);
      end

      valid = (bus.primo != MV_NONE) && (bus.secondo != MV_NONE) && !repeat_block;

      if (valid) begin
         rounds_nx = bus.rounds + 1'b1;
         if (p1_beats) begin
            outcome   = RES_P1;
            score1_nx = bus.score1 + 1'b1;
         end else if (p2_beats) begin
            outcome   = RES_P2;
            score2_nx = bus.score2 + 1'b1;
         end else begin
            outcome   = RES_DRAW;
         end
      end

      // Magnitude difference taken one bit wider so it can never wrap.
      if (score1_nx >= score2_nx) lead = {1'b0, score1_nx} - {1'b0, score2_nx};
      else                        lead = {1'b0, score2_nx} - {1'b0, score1_nx};

      finish = valid &&
               ((rounds_nx == max_rounds) ||
                ((rounds_nx >= CNT_W'(MIN_ROUNDS)) && (lead >= (CNT_W+1)'(WIN_LEAD))));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_PLAY;
         max_rounds    <= CNT_W'(MIN_ROUNDS) + CNT_W'({bus.primo, bus.secondo});
         last_winner   <= RES_NONE;
         last_move     <= MV_NONE;
         bus.manche    <= RES_NONE;
         bus.partita   <= RES_NONE;
         bus.score1    <= '0;
         bus.score2    <= '0;
         bus.rounds    <= '0;
         bus.game_over <= 1'b0;
      end else begin
         case (state)
            ST_PLAY: begin
               bus.manche <= outcome;
               if (valid) begin
                  bus.rounds <= rounds_nx;
                  bus.score1 <= score1_nx;
                  bus.score2 <= score2_nx;
                  if (outcome == RES_DRAW) begin
                     last_winner <= RES_NONE;
                     last_move   <= MV_NONE;
                  end else begin
                     last_winner <= outcome;
                     last_move   <= (outcome == RES_P1) ? bus.primo : bus.secondo;
                  end
               end
               if (finish) begin
                  state         <= ST_OVER;
                  bus.game_over <= 1'b1;
                  if (score1_nx > score2_nx)      bus.partita <= RES_P1;
                  else if (score2_nx > score1_nx) bus.partita <= RES_P2;
                  else                            bus.partita <= RES_DRAW;
               end
            end
            ST_OVER: begin
               // Finished game: moves ignored, everything held until reset.
               bus.manche <= RES_NONE;
            end
            default: state <= ST_PLAY;
         endcase
      end
   end

endmodule
